coin_key_filter: RTL and testbench

Front-end stage for the cola vending state machine. Takes the two raw, bouncy, active-low coin keys (0.5-unit and 1-unit) and synchronises and debounces each one. Emits exactly one single-cycle, mutually exclusive pulse per accepted press, on the outputs that drive the vending FSM's `pi_money_half` / `pi_money_one` inputs. Also keeps a running total of accepted money for display.

---
 rtl/coin_key_filter.sv | 146 ++++++++++++++
 tb/tb_coin_key_filter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/coin_key_filter.sv
// Coin key front end: sync + debounce two active-low keys, one pulse per press.
// Latency: pulse appears CNT_MAX+4 edges after the first raw low sample.
// Backpressure: none; pulses are fire-and-forget, half has priority over one.
module coin_key_filter #(
  parameter int CNT_MAX = 999_999,
  parameter int CNT_W   = 20
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_half,
  input  logic       key_one,
  output logic       po_money_half,
  output logic       po_money_one,
  output logic [7:0] po_coin_sum
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_FILT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_FILT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Channel 0 is the half-unit key, channel 1 the one-unit key.
  logic [1:0] key_raw;
  logic [1:0] pend_set;

  assign key_raw = {key_one, key_half};

  for (genvar c = 0; c < 2; c++) begin : g_chan
    logic             sync1_q;
    logic             ks_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    // Two-flop synchroniser; idles high like an unpressed key.
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        sync1_q <= 1'b1;
        ks_q    <= 1'b1;
      end else begin
        sync1_q <= key_raw[c];
        ks_q    <= sync1_q;
      end
    end

    // Debounce FSM: a level must hold CNT_MAX+2 samples to be believed.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
        IDLE: begin
          if (!ks_q) begin
            state_d = PRESS_FILT;
            cnt_d   = '0;
          end
        end
        PRESS_FILT: begin
          if (ks_q) begin
            state_d = IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_d = HELD;
            accept  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        HELD: begin
          if (ks_q) begin
            state_d = RELEASE_FILT;
            cnt_d   = '0;
          end
        end
        RELEASE_FILT: begin
          if (!ks_q) begin
            state_d = HELD;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Debounce state and counter registers.
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign pend_set[c] = accept;
  end

  logic [1:0] pend_q, pend_d;
  logic       half_q, half_d;
  logic       one_q, one_d;
  logic [7:0] sum_q, sum_d;

  // Arbiter: drain one pending coin per cycle, half first; a new set wins over a clear.
  always_comb begin
    pend_d = pend_q;
    half_d = 1'b0;
    one_d  = 1'b0;
    sum_d  = sum_q;
    if (pend_q[0]) begin
      half_d    = 1'b1;
      pend_d[0] = 1'b0;
      sum_d     = sum_q + 8'd1;
    end else if (pend_q[1]) begin
      one_d     = 1'b1;
      pend_d[1] = 1'b0;
      sum_d     = sum_q + 8'd2;
    end
    pend_d = pend_d | pend_set;
  end

  // Pending flags, output pulses and running total (wraps naturally at 256).
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pend_q <= '0;
      half_q <= 1'b0;
      one_q  <= 1'b0;
      sum_q  <= '0;
    end else begin
      pend_q <= pend_d;
      half_q <= half_d;
      one_q  <= one_d;
      sum_q  <= sum_d;
    end
  end

  assign po_money_half = half_q;
  assign po_money_one  = one_q;
  assign po_coin_sum   = sum_q;

endmodule

// File: tb/tb_coin_key_filter.sv
// Bench for coin_key_filter with CNT_MAX=9: table of press lengths plus corner sequences.
// Latency: expects a pulse 14 edge-counts after the key is driven low.
// Backpressure: not applicable; pulses are counted by a negedge monitor.
module tb_coin_key_filter;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       key_half = 1'b1;
  logic       key_one  = 1'b1;
  logic       po_money_half;
  logic       po_money_one;
  logic [7:0] po_coin_sum;

  coin_key_filter #(.CNT_MAX(9), .CNT_W(20)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .key_half     (key_half),
    .key_one      (key_one),
    .po_money_half(po_money_half),
    .po_money_one (po_money_one),
    .po_coin_sum  (po_coin_sum)
  );

  always #5 sys_clk = ~sys_clk;

  int edge_cnt = 0;
  always @(posedge sys_clk) edge_cnt <= edge_cnt + 1;

  // Pulse monitor, sampled mid-cycle.
  int n_half = 0, n_one = 0, n_both = 0;
  int half_edge = -1, one_edge = -1;
  always @(negedge sys_clk) begin
    if (po_money_half) begin
      n_half    <= n_half + 1;
      half_edge <= edge_cnt;
    end
    if (po_money_one) begin
      n_one    <= n_one + 1;
      one_edge <= edge_cnt;
    end
    if (po_money_half && po_money_one) n_both <= n_both + 1;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic do_reset(input string name);
    sys_rst = 1'b1;
    step(1);
    chk({name, "_rst_half"}, int'(po_money_half), 0);
    chk({name, "_rst_one"},  int'(po_money_one), 0);
    chk({name, "_rst_sum"},  int'(po_coin_sum), 0);
    sys_rst = 1'b0;
  endtask

  // Single press of one key: low for 'low' cycles, then released and settled.
  task automatic press(input logic half, input logic one, input int low);
    key_half = ~half;
    key_one  = ~one;
    step(low);
    key_half = 1'b1;
    key_one  = 1'b1;
    step(25);
  endtask

  typedef struct {
    string      name;
    logic       half;
    logic       one;
    int         low_cyc;
    int         exp_half;   // cumulative since table start
    int         exp_one;
    logic [7:0] exp_sum;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int bh, bo, t0;

    tbl[0] = '{"clean_half", 1'b1, 1'b0, 30, 1, 0, 8'd1};
    tbl[1] = '{"clean_one",  1'b0, 1'b1, 30, 1, 1, 8'd3};
    tbl[2] = '{"half_10",    1'b1, 1'b0, 10, 1, 1, 8'd3};
    tbl[3] = '{"half_11",    1'b1, 1'b0, 11, 2, 1, 8'd4};
    tbl[4] = '{"one_10",     1'b0, 1'b1, 10, 2, 1, 8'd4};
    tbl[5] = '{"one_11",     1'b0, 1'b1, 11, 2, 2, 8'd6};
    tbl[6] = '{"both_20",    1'b1, 1'b1, 20, 3, 3, 8'd9};
    tbl[7] = '{"glitch_1",   1'b1, 1'b0, 1,  3, 3, 8'd9};

    step(2);
    do_reset("init");
    step(3);

    // Table: press lengths around the acceptance threshold.
    bh = n_half; bo = n_one;
    for (int i = 0; i < 8; i++) begin
      press(tbl[i].half, tbl[i].one, tbl[i].low_cyc);
      chk({tbl[i].name, "_nhalf"}, n_half - bh, tbl[i].exp_half);
      chk({tbl[i].name, "_none"},  n_one - bo,  tbl[i].exp_one);
      chk({tbl[i].name, "_sum"},   int'(po_coin_sum), int'(tbl[i].exp_sum));
    end

    // Clean press latency.
    do_reset("lat");
    bh = n_half;
    t0 = edge_cnt;
    key_half = 1'b0;
    step(30);
    key_half = 1'b1;
    step(25);
    chk("lat_count", n_half - bh, 1);
    chk("lat_edge",  half_edge, t0 + 14);
    chk("lat_sum",   int'(po_coin_sum), 1);

    // Bouncy press on the one key.
    do_reset("bounce");
    bo = n_one;
    for (int i = 0; i < 40; i++) begin
      key_one = ((i / 3) % 2) != 0;
      step(1);
    end
    step(1);
    chk("bounce_quiet", n_one - bo, 0);
    t0 = edge_cnt;
    key_one = 1'b0;
    step(30);
    key_one = 1'b1;
    step(25);
    chk("bounce_count", n_one - bo, 1);
    chk("bounce_edge",  one_edge, t0 + 14);
    chk("bounce_sum",   int'(po_coin_sum), 2);

    // Simultaneous acceptance: half first, one on the next cycle.
    do_reset("simul");
    bh = n_half; bo = n_one;
    t0 = edge_cnt;
    press(1'b1, 1'b1, 30);
    chk("simul_half_edge", half_edge, t0 + 14);
    chk("simul_one_edge",  one_edge,  t0 + 15);
    chk("simul_counts",    (n_half - bh) * 10 + (n_one - bo), 11);
    chk("simul_sum",       int'(po_coin_sum), 3);

    // Long hold, bouncy release, then a clean re-press.
    do_reset("hold");
    bh = n_half;
    key_half = 1'b0;
    step(100);
    for (int i = 0; i < 20; i++) begin
      key_half = ((i / 2) % 2) != 0;
      step(1);
    end
    key_half = 1'b1;
    step(30);
    chk("hold_one_pulse", n_half - bh, 1);
    press(1'b1, 1'b0, 30);
    chk("hold_two_pulses", n_half - bh, 2);
    chk("hold_sum",        int'(po_coin_sum), 2);

    // Reset while the one key is mid-filter (cnt=5), key kept low.
    do_reset("mid");
    bo = n_one;
    t0 = edge_cnt;
    key_one = 1'b0;
    step(8);
    do_reset("mid_post");
    t0 = edge_cnt;
    step(30);
    key_one = 1'b1;
    step(25);
    chk("mid_count", n_one - bo, 1);
    chk("mid_edge",  one_edge, t0 + 14);
    chk("mid_sum",   int'(po_coin_sum), 2);

    // Sum wrap: 128 one-presses give 256 = 0, one more gives 2.
    do_reset("wrap");
    bo = n_one;
    for (int i = 0; i < 128; i++) press(1'b0, 1'b1, 15);
    chk("wrap_count", n_one - bo, 128);
    chk("wrap_zero",  int'(po_coin_sum), 0);
    press(1'b0, 1'b1, 15);
    chk("wrap_two",   int'(po_coin_sum), 2);

    // 255 + 2 wraps to 1.
    do_reset("wrap2");
    press(1'b1, 1'b0, 15);
    for (int i = 0; i < 127; i++) press(1'b0, 1'b1, 15);
    chk("wrap2_255", int'(po_coin_sum), 255);
    press(1'b0, 1'b1, 15);
    chk("wrap2_one", int'(po_coin_sum), 1);

    chk("never_both", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
